multicycle_controller: RTL and testbench

Multi-cycle main control FSM for the RISC-V datapath (R-format, LD, SD, BEQ). It replaces the single-cycle opcode decoder with a sequenced controller, so one memory port and one ALU are reused across the fetch, decode, execute, memory and writeback steps. It handshakes with a variable-latency unified memory and counts retired instructions. It sits between the instruction register (opcode source) and every datapath mux and write enable.

---
 rtl/controller_pkg.sv | 31 +++
 rtl/multicycle_controller.sv | 161 ++++++++++++++++
 tb/tb_multicycle_controller.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/controller_pkg.sv
// Shared encodings for the multi-cycle RISC-V main controller: FSM states,
// supported opcodes and the ALU control field values.
package controller_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADDR  = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_RWB      = 4'd7,
        S_BRANCH   = 4'd8,
        S_TRAP     = 4'd9
    } state_e;

    localparam logic [6:0] R_TYPE = 7'b0110011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

endpackage

// File: rtl/multicycle_controller.sv
// Multi-cycle main control FSM: sequences fetch/decode/execute/memory/writeback
// over one memory port and one ALU, and counts retired instructions.
module multicycle_controller
    import controller_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [6:0]  opcode,
    input  logic        memoryReady,
    output logic        PCWrite,
    output logic        branch,
    output logic        PCSource,
    output logic        IorD,
    output logic        memoryRead,
    output logic        memoryWrite,
    output logic        IRWrite,
    output logic        memoryToRegister,
    output logic        regWrite,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ALUOp,
    output logic        illegal,
    output logic [3:0]  state,
    output logic [31:0] instrCount
);

    state_e      state_q;
    state_e      next_state;
    logic [31:0] instr_count_q;
    logic        illegal_q;
    logic        retire;

    // NOTE: every state register lives in one always_ff with non-blocking
    // assignments, so all of them update from the same pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_FETCH;
            instr_count_q <= '0;
            illegal_q     <= 1'b0;
        end else begin
            state_q       <= next_state;
            instr_count_q <= instr_count_q + {31'd0, retire};
            if (next_state == S_TRAP) begin
                illegal_q <= 1'b1;
            end
        end
    end

    always_comb begin
        next_state = S_FETCH;
        case (state_q)
            S_FETCH:    next_state = memoryReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    R_TYPE:        next_state = S_EXECUTE;
                    LOAD, STORE:   next_state = S_MEMADDR;
                    BRANCH:        next_state = S_BRANCH;
                    default:       next_state = S_TRAP;
                endcase
            end
            S_MEMADDR:  next_state = (opcode == LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  next_state = memoryReady ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    next_state = S_FETCH;
            S_MEMWRITE: next_state = memoryReady ? S_FETCH : S_MEMWRITE;
            S_EXECUTE:  next_state = S_RWB;
            S_RWB:      next_state = S_FETCH;
            S_BRANCH:   next_state = S_FETCH;
            S_TRAP:     next_state = S_TRAP;
            default:    next_state = S_FETCH;
        endcase
    end

    // A retirement is the step back into FETCH from a final instruction state.
    always_comb begin
        retire = 1'b0;
        if (!reset && next_state == S_FETCH) begin
            case (state_q)
                S_MEMWB, S_MEMWRITE, S_RWB, S_BRANCH: retire = 1'b1;
                default:                              retire = 1'b0;
            endcase
        end
    end

    // NOTE: every output gets a default before the case, so no path through
    // this block leaves a signal unassigned and no latch is inferred.
    always_comb begin
        PCWrite          = 1'b0;
        branch           = 1'b0;
        PCSource         = 1'b0;
        IorD             = 1'b0;
        memoryRead       = 1'b0;
        memoryWrite      = 1'b0;
        IRWrite          = 1'b0;
        memoryToRegister = 1'b0;
        regWrite         = 1'b0;
        ALUSrcA          = 1'b0;
        ALUSrcB          = SRCB_RS2;
        ALUOp            = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                memoryRead = 1'b1;
                ALUSrcB    = SRCB_FOUR;
                IRWrite    = memoryReady;
                PCWrite    = memoryReady;
            end
            S_DECODE: begin
                ALUSrcB = SRCB_IMM;
            end
            S_MEMADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMREAD: begin
                memoryRead = 1'b1;
                IorD       = 1'b1;
            end
            S_MEMWB: begin
                regWrite         = 1'b1;
                memoryToRegister = 1'b1;
            end
            S_MEMWRITE: begin
                memoryWrite = 1'b1;
                IorD        = 1'b1;
            end
            S_EXECUTE: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALU_FUNCT;
            end
            S_RWB: begin
                regWrite = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA  = 1'b1;
                ALUOp    = ALU_SUB;
                branch   = 1'b1;
                PCSource = 1'b1;
            end
            default: ;
        endcase
        // Reset aborts the current step at once, even before the clock edge.
        if (reset) begin
            PCWrite          = 1'b0;
            branch           = 1'b0;
            PCSource         = 1'b0;
            IorD             = 1'b0;
            memoryRead       = 1'b0;
            memoryWrite      = 1'b0;
            IRWrite          = 1'b0;
            memoryToRegister = 1'b0;
            regWrite         = 1'b0;
            ALUSrcA          = 1'b0;
            ALUSrcB          = SRCB_RS2;
            ALUOp            = ALU_ADD;
        end
    end

    assign state      = state_q;
    assign instrCount = instr_count_q;
    assign illegal    = illegal_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: an instruction-level model emits
// the expected per-cycle state/control/count trace, a monitor compares it.
module tb_multicycle_controller;

    logic        clock = 1'b0;
    logic        reset;
    logic [6:0]  opcode;
    logic        memoryReady;
    logic        PCWrite, branch, PCSource, IorD, memoryRead, memoryWrite;
    logic        IRWrite, memoryToRegister, regWrite, ALUSrcA;
    logic [1:0]  ALUSrcB, ALUOp;
    logic        illegal;
    logic [3:0]  state;
    logic [31:0] instrCount;

    multicycle_controller dut (
        .clock(clock), .reset(reset), .opcode(opcode), .memoryReady(memoryReady),
        .PCWrite(PCWrite), .branch(branch), .PCSource(PCSource), .IorD(IorD),
        .memoryRead(memoryRead), .memoryWrite(memoryWrite), .IRWrite(IRWrite),
        .memoryToRegister(memoryToRegister), .regWrite(regWrite), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .illegal(illegal), .state(state),
        .instrCount(instrCount)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [3:0]  st;
        logic [13:0] ctl;
        logic [31:0] cnt;
        logic        ill;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_count = 0;
    logic        model_illegal = 1'b0;
    bit          do_force = 1'b0;
    bit          do_release = 1'b0;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_SD = 7'b0100011;
    localparam logic [6:0] OP_BQ = 7'b1100011;
    localparam logic [6:0] OP_BAD = 7'b0010011;

    // Control word: {PCWrite,branch,PCSource,IorD,memRead,memWrite,IRWrite,mem2reg,regWrite,srcA,srcB[1:0],op[1:0]}
    function automatic logic [13:0] cw(input logic pcw, input logic br, input logic pcs,
                                       input logic iord, input logic mr, input logic mw,
                                       input logic irw, input logic m2r, input logic rw,
                                       input logic sa, input logic [1:0] sb, input logic [1:0] op);
        return {pcw, br, pcs, iord, mr, mw, irw, m2r, rw, sa, sb, op};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h time=%0t", name, act, req, $time);
        end
    endtask

    // One clock cycle: drive inputs just after the edge and queue what the DUT must show.
    task automatic step(input logic [6:0] op, input logic rdy, input logic rst,
                        input logic [3:0] est, input logic [13:0] ectl);
        exp_t e;
        @(posedge clock);
        #1;
        if (do_force) begin
            force dut.instr_count_q = 32'hFFFF_FFFF;
            model_count = 32'hFFFF_FFFF;
            do_force = 1'b0;
        end
        if (do_release) begin
            release dut.instr_count_q;
            do_release = 1'b0;
        end
        opcode      = op;
        memoryReady = rdy;
        reset       = rst;
        e.st  = est;
        e.ctl = ectl;
        e.cnt = model_count;
        e.ill = model_illegal;
        exp_q.push_back(e);
    endtask

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [6:0] rop();
        return 7'($urandom());
    endfunction

    task automatic do_fetch(input int waits);
        for (int i = 0; i < waits; i++)
            step(rop(), 1'b0, 1'b0, 4'd0, cw(0,0,0,0,1,0,0,0,0,0,2'b01,2'b00));
        step(rop(), 1'b1, 1'b0, 4'd0, cw(1,0,0,0,1,0,1,0,0,0,2'b01,2'b00));
    endtask

    task automatic do_decode(input logic [6:0] op);
        step(op, rbit(), 1'b0, 4'd1, cw(0,0,0,0,0,0,0,0,0,0,2'b10,2'b00));
    endtask

    task automatic do_reset(input logic [3:0] cur);
        step(rop(), rbit(), 1'b1, cur, 14'd0);
        model_count   = 0;
        model_illegal = 1'b0;
    endtask

    // kind: 0 = R, 1 = LD, 2 = SD, 3 = BEQ
    task automatic do_instr(input int kind, input int fwait, input int mwait);
        logic [6:0] op;
        case (kind)
            0: op = OP_R;
            1: op = OP_LD;
            2: op = OP_SD;
            default: op = OP_BQ;
        endcase
        do_fetch(fwait);
        do_decode(op);
        case (kind)
            0: begin
                step(op, rbit(), 1'b0, 4'd6, cw(0,0,0,0,0,0,0,0,0,1,2'b00,2'b10));
                step(op, rbit(), 1'b0, 4'd7, cw(0,0,0,0,0,0,0,0,1,0,2'b00,2'b00));
            end
            1: begin
                step(op, rbit(), 1'b0, 4'd2, cw(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00));
                for (int i = 0; i < mwait; i++)
                    step(op, 1'b0, 1'b0, 4'd3, cw(0,0,0,1,1,0,0,0,0,0,2'b00,2'b00));
                step(op, 1'b1, 1'b0, 4'd3, cw(0,0,0,1,1,0,0,0,0,0,2'b00,2'b00));
                step(op, rbit(), 1'b0, 4'd4, cw(0,0,0,0,0,0,0,1,1,0,2'b00,2'b00));
            end
            2: begin
                step(op, rbit(), 1'b0, 4'd2, cw(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00));
                for (int i = 0; i < mwait; i++)
                    step(op, 1'b0, 1'b0, 4'd5, cw(0,0,0,1,0,1,0,0,0,0,2'b00,2'b00));
                step(op, 1'b1, 1'b0, 4'd5, cw(0,0,0,1,0,1,0,0,0,0,2'b00,2'b00));
            end
            default: begin
                step(op, rbit(), 1'b0, 4'd8, cw(0,1,1,0,0,0,0,0,0,1,2'b00,2'b01));
            end
        endcase
        model_count = model_count + 1;
    endtask

    always @(negedge clock) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("state", {28'd0, state}, {28'd0, e.st});
            check("controls", {18'd0, PCWrite, branch, PCSource, IorD, memoryRead, memoryWrite,
                               IRWrite, memoryToRegister, regWrite, ALUSrcA, ALUSrcB, ALUOp},
                  {18'd0, e.ctl});
            check("instrCount", instrCount, e.cnt);
            check("illegal", {31'd0, illegal}, {31'd0, e.ill});
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        opcode = '0;
        memoryReady = 1'b0;
        @(posedge clock);
        do_reset(4'd0);

        // Directed: R with zero wait, LD with 3 waits, SD zero wait, BEQ.
        do_instr(0, 0, 0);
        do_instr(1, 0, 3);
        do_instr(2, 0, 0);
        do_instr(3, 0, 0);

        // Counter wrap: preload to all-ones and retire one R instruction.
        do_force = 1'b1;
        do_fetch(0);
        do_decode(OP_R);
        step(OP_R, rbit(), 1'b0, 4'd6, cw(0,0,0,0,0,0,0,0,0,1,2'b00,2'b10));
        do_release = 1'b1;
        step(OP_R, rbit(), 1'b0, 4'd7, cw(0,0,0,0,0,0,0,0,1,0,2'b00,2'b00));
        model_count = model_count + 1;
        do_instr(3, 1, 0);

        // Reset while MEMWRITE waits on memory.
        do_fetch(0);
        do_decode(OP_SD);
        step(OP_SD, rbit(), 1'b0, 4'd2, cw(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00));
        step(OP_SD, 1'b0, 1'b0, 4'd5, cw(0,0,0,1,0,1,0,0,0,0,2'b00,2'b00));
        step(OP_SD, 1'b0, 1'b0, 4'd5, cw(0,0,0,1,0,1,0,0,0,0,2'b00,2'b00));
        do_reset(4'd5);

        // Randomized instruction mix with random memory latency.
        for (int n = 0; n < 40; n++)
            do_instr($urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 3));

        // Unsupported opcode traps and sticks until reset.
        do_fetch(0);
        do_decode(OP_BAD);
        model_illegal = 1'b1;
        for (int i = 0; i < 6; i++)
            step(OP_BAD, rbit(), 1'b0, 4'd9, 14'd0);
        do_reset(4'd9);
        do_instr(0, 0, 0);

        repeat (2) @(posedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
